uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_sync2.sv | 20 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period,
// intended to be reused by the transmit side.
package uart_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_e;

  // 27 MHz / 115200 baud
  localparam int unsigned DELAY_FRAMES_DEF = 234;
  localparam int unsigned CNT_W            = 16;
endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous input; resets to 1
// so a reset never looks like a start bit.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling on the synchronized line, registered
// byte/ready outputs and a one-cycle pulse on a bad stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DELAY_FRAMES = DELAY_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uartRx,
  output logic       byteReady,
  output logic [7:0] dataOut,
  output logic       frameError
);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(DELAY_FRAMES / 2);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DELAY_FRAMES - 1);

  logic             rxS;
  uartState_e       state, stateN;
  logic [CNT_W-1:0] cnt, cntN;
  logic [2:0]       idx, idxN;
  logic [7:0]       shreg, shregN;
  logic [7:0]       dataOutN;
  logic             byteReadyN, frameErrorN;
  logic             rdyHold, rdyHoldN;
  logic             armed, armedN;
  logic             errWait, errWaitN;

  sync2 uSync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (uartRx),
    .q    (rxS)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      dataOut    <= '0;
      byteReady  <= 1'b0;
      frameError <= 1'b0;
      rdyHold    <= 1'b0;
      armed      <= 1'b0;
      errWait    <= 1'b0;
    end else begin
      state      <= stateN;
      cnt        <= cntN;
      idx        <= idxN;
      shreg      <= shregN;
      dataOut    <= dataOutN;
      byteReady  <= byteReadyN;
      frameError <= frameErrorN;
      rdyHold    <= rdyHoldN;
      armed      <= armedN;
      errWait    <= errWaitN;
    end
  end

  always_comb begin
    stateN      = state;
    cntN        = cnt;
    idxN        = idx;
    shregN      = shreg;
    dataOutN    = dataOut;
    byteReadyN  = byteReady;
    frameErrorN = 1'b0;
    rdyHoldN    = rdyHold;
    armedN      = armed;
    errWaitN    = errWait;

    unique case (state)
      IDLE: begin
        if (!armed) begin
          // After reset, demand two bit times of idle-high so the tail of an
          // abandoned frame cannot be mistaken for a fresh start bit.
          if (!rxS) begin
            cntN = '0;
            idxN = '0;
          end else if (cnt == FULL_M1) begin
            cntN = '0;
            if (idx == 3'd1) begin
              armedN = 1'b1;
              idxN   = '0;
            end else begin
              idxN = idx + 3'd1;
            end
          end else begin
            cntN = cnt + 1'b1;
          end
        end else if (!rxS) begin
          stateN     = START;
          cntN       = '0;
          rdyHoldN   = byteReady;
          byteReadyN = 1'b0;
        end
      end

      START: begin
        if (cnt == HALF) begin
          cntN = '0;
          if (!rxS) begin
            stateN = DATA;
            idxN   = '0;
          end else begin
            stateN     = IDLE;
            byteReadyN = rdyHold;
          end
        end else begin
          cntN = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == FULL_M1) begin
          cntN        = '0;
          shregN[idx] = rxS;
          idxN        = idx + 3'd1;
          if (idx == 3'd7) stateN = STOP;
        end else begin
          cntN = cnt + 1'b1;
        end
      end

      STOP: begin
        if (errWait) begin
          // Hold here through a break so it raises only one error.
          if (rxS) begin
            errWaitN = 1'b0;
            stateN   = IDLE;
          end
        end else if (cnt == FULL_M1) begin
          cntN = '0;
          if (rxS) begin
            dataOutN   = shreg;
            byteReadyN = 1'b1;
            stateN     = IDLE;
          end else begin
            frameErrorN = 1'b1;
            errWaitN    = 1'b1;
          end
        end else begin
          cntN = cnt + 1'b1;
        end
      end

      default: stateN = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: frames are generated bit by bit and
// received bytes are checked against an expected-byte queue.
module tb_uart_rx;
  localparam int D  = 8;
  localparam int D2 = 234;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uartRx = 1'b1;
  logic       uartRx2 = 1'b1;
  logic       byteReady, frameError, byteReady2, frameError2;
  logic [7:0] dataOut, dataOut2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rises = 0, rises2 = 0, ferrCnt = 0, ferrCnt2 = 0;
  int lastRiseCyc = 0, lastFallCyc = 0;
  logic prevRdy = 1'b0, prevRdy2 = 1'b0;
  logic [7:0] rxq[$], rxq2[$], expq[$];
  logic [7:0] lastGood = 8'h00;

  uart_rx #(.DELAY_FRAMES(D)) dut (
    .clk(clk), .rst_n(rst_n), .uartRx(uartRx),
    .byteReady(byteReady), .dataOut(dataOut), .frameError(frameError)
  );

  uart_rx #(.DELAY_FRAMES(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .uartRx(uartRx2),
    .byteReady(byteReady2), .dataOut(dataOut2), .frameError(frameError2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Observe outputs mid-cycle: rising edges of byteReady deliver a byte.
  always @(negedge clk) begin
    if (byteReady && !prevRdy) begin
      rises++;
      lastRiseCyc = cyc;
      rxq.push_back(dataOut);
    end
    if (!byteReady && prevRdy) lastFallCyc = cyc;
    if (frameError) ferrCnt++;
    prevRdy = byteReady;
    if (byteReady2 && !prevRdy2) begin
      rises2++;
      rxq2.push_back(dataOut2);
    end
    if (frameError2) ferrCnt2++;
    prevRdy2 = byteReady2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame; startEdge is the first clock edge that sees the start bit.
  task automatic send(input logic [7:0] b, input logic stopBit, input bit sel,
                      output int startEdge);
    logic [9:0] bits;
    int d;
    bits = {stopBit, b, 1'b0};
    d = sel ? D2 : D;
    startEdge = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      if (sel) uartRx2 = bits[i];
      else     uartRx  = bits[i];
      step(d);
    end
    if (sel) uartRx2 = 1'b1;
    else     uartRx  = 1'b1;
  endtask

  task automatic sendModel(input logic [7:0] b, input logic stopBit, output int startEdge);
    send(b, stopBit, 1'b0, startEdge);
    if (stopBit) begin
      expq.push_back(b);
      lastGood = b;
    end
  endtask

  task automatic checkQueue(input string tag);
    logic [31:0] o;
    check({tag, "_count"}, rxq.size(), expq.size());
    foreach (expq[i]) begin
      o = (i < rxq.size()) ? 32'(rxq[i]) : 'x;
      check(tag, o, 32'(expq[i]));
    end
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    int se, r0, f0, fl;
    logic [7:0] rb;
    logic [9:0] bits;
    string txt;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_dataOut", dataOut, 8'h00);
    check("rst_byteReady", byteReady, 1'b0);
    check("rst_frameError", frameError, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(4 * D);

    // Single byte and its exact latency
    sendModel(8'h41, 1'b1, se);
    step(4);
    check("lat_rise_0x41", lastRiseCyc - se, 79);
    check("data_0x41", dataOut, 8'h41);
    check("ready_0x41", byteReady, 1'b1);
    check("no_ferr_0x41", ferrCnt, 0);

    // Next frame: byteReady must drop soon after the start edge
    rb = 8'($urandom_range(0, 255));
    sendModel(rb, 1'b1, se);
    step(4);
    fl = lastFallCyc - se;
    check("fall_within_3", (fl >= 0 && fl <= 3), 1'b1);
    check("lat_rise_rand", lastRiseCyc - se, 79);
    checkQueue("first_bytes");

    // Back-to-back frames, no idle gap
    r0 = rises;
    sendModel(8'h00, 1'b1, se);
    sendModel(8'hFF, 1'b1, se);
    step(2 * D);
    check("b2b_edges", rises - r0, 2);
    checkQueue("b2b");

    // Random bytes with small random gaps
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom_range(0, 255));
      sendModel(rb, 1'b1, se);
      step($urandom_range(0, 3));
    end
    step(2 * D);
    checkQueue("rand");

    // Bad stop bit, then a good byte
    f0 = ferrCnt;
    sendModel(8'h55, 1'b0, se);
    step(3 * D);
    check("ferr_pulses", ferrCnt - f0, 1);
    check("ferr_data_kept", dataOut, lastGood);
    check("ferr_ready_low", byteReady, 1'b0);
    sendModel(8'h31, 1'b1, se);
    step(4);
    check("after_ferr_data", dataOut, 8'h31);
    check("after_ferr_ready", byteReady, 1'b1);
    checkQueue("ferr");

    // Short glitch on an idle line
    uartRx = 1'b0;
    step(2);
    uartRx = 1'b1;
    step(3 * D);
    check("glitch_ready", byteReady, 1'b1);
    check("glitch_data", dataOut, 8'h31);
    rxq.delete();

    // Break: line held low for many frames
    f0 = ferrCnt;
    uartRx = 1'b0;
    step(30 * D);
    uartRx = 1'b1;
    step(3 * D);
    check("break_one_ferr", ferrCnt - f0, 1);
    check("break_ready_low", byteReady, 1'b0);
    rb = 8'($urandom_range(0, 255));
    sendModel(rb, 1'b1, se);
    step(4);
    checkQueue("after_break");

    // Reset during data bit 3 of 0xA5, released mid-frame
    r0 = rises;
    bits = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uartRx = bits[i];
      for (int c = 0; c < D; c++) begin
        if (i == 4 && c == 3) begin
          rst_n = 1'b0;
          #2;
          check("midrst_data", dataOut, 8'h00);
          check("midrst_ready", byteReady, 1'b0);
          check("midrst_ferr", frameError, 1'b0);
        end
        if (i == 4 && c == 4) rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    uartRx = 1'b1;
    lastGood = 8'h00;
    step(3 * D);
    check("abandoned_no_edge", rises - r0, 0);
    check("abandoned_data", dataOut, 8'h00);
    sendModel(8'h5A, 1'b1, se);
    step(4);
    check("post_rst_data", dataOut, 8'h5A);
    checkQueue("post_rst");

    // Full-rate instance: 16 text bytes back-to-back
    step(3 * D2);
    txt = "0123456789abcdef";
    for (int i = 0; i < 16; i++) send(txt[i], 1'b1, 1'b1, se);
    step(3 * D2);
    check("text_edges", rises2, 16);
    check("text_ferr", ferrCnt2, 0);
    for (int i = 0; i < 16; i++)
      check("text_byte", (i < rxq2.size()) ? 32'(rxq2[i]) : 'x, 32'(txt[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
